// File: rtl/nonce_result_fifo.sv
// nonce_result_fifo: captures comparator hits and queues {hash, nonce} for the host reader; define HIT_STATS_EN for hit/drop counters
module nonce_result_fifo #(
  parameter int DEPTH   = 4,
  parameter int NONCE_W = 32,
  parameter int HASH_W  = 256
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic                       enable,
  input  logic                       clear,
  input  logic                       cmp_valid,
  input  logic                       cmp_out,
  input  logic [HASH_W-1:0]          cmp_hash,
  input  logic [NONCE_W-1:0]         cmp_nonce,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [HASH_W-1:0]          res_hash,
  output logic [NONCE_W-1:0]         res_nonce,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level,
  output logic                       overflow
`ifdef HIT_STATS_EN
  ,
  output logic [31:0]                hit_count,
  output logic [31:0]                drop_count
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int EW = HASH_W + NONCE_W;

  logic               stage_valid_q, stage_valid_d;
  logic [HASH_W-1:0]  stage_hash_q, stage_hash_d;
  logic [NONCE_W-1:0] stage_nonce_q, stage_nonce_d;
  logic [EW-1:0]      mem_q [DEPTH];
  logic [EW-1:0]      mem_d [DEPTH];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]      level_q, level_d;
  logic               overflow_q, overflow_d;
  logic               capture, full, pop, wr_en, drop;
  logic [EW-1:0]      head;

  assign capture    = cmp_valid & cmp_out & enable & ~clear;
  assign full       = level_q == LW'(DEPTH);
  assign pop        = res_valid & res_ready;
  assign wr_en      = stage_valid_q & (~full | pop) & ~clear;
  assign drop       = stage_valid_q & full & ~pop & ~clear;
  assign head       = mem_q[rd_ptr_q];
  assign res_valid  = level_q != '0;
  assign res_hash   = head[EW-1:NONCE_W];
  assign res_nonce  = head[NONCE_W-1:0];
  assign fifo_level = level_q;
  assign overflow   = overflow_q;

  // next state: capture stage, FIFO pointers/level, sticky overflow; clear dominates push and pop
  always_comb begin
    stage_valid_d = capture;
    stage_hash_d  = capture ? cmp_hash : stage_hash_q;
    stage_nonce_d = capture ? cmp_nonce : stage_nonce_q;
    wr_ptr_d      = clear ? '0 : wr_ptr_q + PW'(wr_en);
    rd_ptr_d      = clear ? '0 : rd_ptr_q + PW'(pop);
    level_d       = clear ? '0 : level_q + LW'(wr_en) - LW'(pop);
    overflow_d    = ~clear & (overflow_q | drop);
    mem_d         = mem_q;
    if (wr_en) mem_d[wr_ptr_q] = {stage_hash_q, stage_nonce_q};
  end

  // state registers; reset also zeroes the data path so res_* read 0
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      stage_valid_q <= 1'b0;
      stage_hash_q  <= '0;
      stage_nonce_q <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      overflow_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      stage_valid_q <= stage_valid_d;
      stage_hash_q  <= stage_hash_d;
      stage_nonce_q <= stage_nonce_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      overflow_q    <= overflow_d;
      mem_q         <= mem_d;
    end
  end

`ifdef HIT_STATS_EN
  logic [31:0] hit_count_q, hit_count_d, drop_count_q, drop_count_d;

  assign hit_count  = hit_count_q;
  assign drop_count = drop_count_q;

  // saturating statistics, untouched by clear
  always_comb begin
    hit_count_d  = (capture && hit_count_q != '1) ? hit_count_q + 32'd1 : hit_count_q;
    drop_count_d = (drop && drop_count_q != '1) ? drop_count_q + 32'd1 : drop_count_q;
  end

  // statistics registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      hit_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      drop_count_q <= drop_count_d;
    end
  end
`endif
endmodule
